// File: rtl/sys_defs.sv
// Shared definitions for the issue stage: superscalar width, rollback encoding,
// the ID/EX packet layout and the issue replay state enum.
package sys_defs;

  localparam int WAYS           = 4;
  localparam int ROLLBACK_WIDTH = 3;
  localparam int KEEP_WIDTH     = $clog2(WAYS + 1);

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
    logic [4:0]  dest_reg;
  } ID_EX_PACKET;

  typedef enum logic {
    PASS   = 1'b0,
    REPLAY = 1'b1
  } ISSUE_STATE;

  // Number of leading ways allowed to issue; rollback beyond WAYS holds everything.
  function automatic logic [KEEP_WIDTH-1:0] keep_ways(input logic [ROLLBACK_WIDTH-1:0] rollback);
    logic [ROLLBACK_WIDTH-1:0] clamped;
    clamped = (rollback > ROLLBACK_WIDTH'(WAYS)) ? ROLLBACK_WIDTH'(WAYS) : rollback;
    return KEEP_WIDTH'(WAYS - int'(clamped));
  endfunction

endpackage

// File: rtl/issue_replay_ctrl_compactor.sv
// replay_compactor: picks the ways that are valid but beyond the keep boundary
// and packs them into slots 0.. in program order.
module replay_compactor
  import sys_defs::*;
(
  input  ID_EX_PACKET [WAYS-1:0] grp_packet,
  input  logic [WAYS-1:0]        grp_valid,
  input  logic [KEEP_WIDTH-1:0]  keep,
  output ID_EX_PACKET [WAYS-1:0] held_packet,
  output logic [WAYS-1:0]        held_valid,
  output logic [KEEP_WIDTH-1:0]  held_count
);

  localparam int IDX_WIDTH = $clog2(WAYS);

  logic [IDX_WIDTH-1:0] slot;

  // Walk the ways oldest first, appending each held one to the next free slot.
  always_comb begin
    // NOTE: every output gets a default before the loop so no path leaves it unassigned (no latch).
    held_packet = '0;
    held_valid  = '0;
    held_count  = '0;
    slot        = '0;
    for (int i = 0; i < WAYS; i++) begin
      if (grp_valid[i] && (i >= int'(keep))) begin
        held_packet[slot] = grp_packet[i];
        held_valid[slot]  = 1'b1;
        held_count        = held_count + KEEP_WIDTH'(1);
        slot              = slot + IDX_WIDTH'(1);
      end
    end
  end

endmodule

// File: rtl/issue_replay_ctrl.sv
// issue_replay_ctrl: holds back the younger ways of an issue group when the
// detection unit requests a rollback and re-presents them the next cycle.
// Optional feature macro: ISSUE_REPLAY_STATS_EN adds rollback/replay counters.
module issue_replay_ctrl
  import sys_defs::*;
#(
  parameter int WATCHDOG_MAX = 63
) (
  input  logic                      clock,
  input  logic                      reset,
  input  ID_EX_PACKET [WAYS-1:0]    id_packet,
  input  logic [WAYS-1:0]           id_valid,
  input  logic                      flush,
  input  logic [ROLLBACK_WIDTH-1:0] rollback,
  output ID_EX_PACKET [WAYS-1:0]    grp_packet,
  output logic [WAYS-1:0]           grp_valid,
  output ID_EX_PACKET [WAYS-1:0]    issue_packet,
  output logic [WAYS-1:0]           issue_valid,
  output logic                      id_stall,
  output logic                      replay_active,
  output logic                      watchdog_err
`ifdef ISSUE_REPLAY_STATS_EN
  ,
  output logic [31:0]               stat_rollback_cycles,
  output logic [31:0]               stat_replayed_insts
`endif
);

  localparam int CNT_WIDTH = $clog2(WATCHDOG_MAX + 1);

  ISSUE_STATE             state, state_d;
  ID_EX_PACKET [WAYS-1:0] buf_packet;
  logic [WAYS-1:0]        buf_valid;
  logic [KEEP_WIDTH-1:0]  keep;
  ID_EX_PACKET [WAYS-1:0] held_packet;
  logic [WAYS-1:0]        held_valid;
  logic [KEEP_WIDTH-1:0]  held_count;
  logic [CNT_WIDTH-1:0]   wd_cnt, wd_cnt_d;

  assign keep          = keep_ways(rollback);
  assign replay_active = (state == REPLAY);

  // Select the group source (decode or replay buffer) and derive the issue mask.
  always_comb begin
    grp_packet = id_packet;
    grp_valid  = id_valid;
    id_stall   = 1'b0;
    if (state == REPLAY) begin
      grp_packet = buf_packet;
      grp_valid  = buf_valid;
      id_stall   = !flush;
    end
    if (reset) grp_valid = '0;
    issue_packet = grp_packet;
    for (int i = 0; i < WAYS; i++) begin
      issue_valid[i] = grp_valid[i] && (i < int'(keep)) && !flush;
    end
  end

  replay_compactor u_compactor (
    .grp_packet  (grp_packet),
    .grp_valid   (grp_valid),
    .keep        (keep),
    .held_packet (held_packet),
    .held_valid  (held_valid),
    .held_count  (held_count)
  );

  // Next state: replay whenever something is held, flush always returns to PASS.
  always_comb begin
    state_d = state;
    if (flush)                  state_d = PASS;
    else if (held_count != '0) state_d = REPLAY;
    else                        state_d = PASS;
  end

  // State register.
  always_ff @(posedge clock or posedge reset) begin
    // NOTE: sequential state uses non-blocking assignment so all flops update together.
    if (reset) state <= PASS;
    else       state <= state_d;
  end

  // Replay buffer occupancy; the held set always lands in slots 0.. compacted.
  always_ff @(posedge clock or posedge reset) begin
    if (reset)      buf_valid <= '0;
    else if (flush) buf_valid <= '0;
    else            buf_valid <= held_valid;
  end

  // Replay buffer payload.
  always_ff @(posedge clock) begin
    // NOTE: payload is left unreset on purpose; buf_valid alone qualifies it.
    buf_packet <= held_packet;
  end

  // Watchdog counter next value: consecutive REPLAY cycles, saturating.
  always_comb begin
    wd_cnt_d = '0;
    if (state == REPLAY) begin
      wd_cnt_d = (wd_cnt == CNT_WIDTH'(WATCHDOG_MAX)) ? wd_cnt : wd_cnt + CNT_WIDTH'(1);
    end
  end

  // Watchdog counter and sticky error flag.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wd_cnt       <= '0;
      watchdog_err <= 1'b0;
    end else begin
      wd_cnt       <= wd_cnt_d;
      watchdog_err <= watchdog_err | (wd_cnt_d == CNT_WIDTH'(WATCHDOG_MAX));
    end
  end

`ifdef ISSUE_REPLAY_STATS_EN
  // Statistics: rollback cycles and total held instructions, ignoring flush cycles.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      stat_rollback_cycles <= '0;
      stat_replayed_insts  <= '0;
    end else if (!flush && (held_count != '0)) begin
      stat_rollback_cycles <= stat_rollback_cycles + 32'd1;
      stat_replayed_insts  <= stat_replayed_insts + 32'(held_count);
    end
  end
`endif

endmodule

// File: tb/tb_issue_replay_ctrl.sv
// Scoreboard bench for issue_replay_ctrl: a queue-based replay model predicts
// each cycle's outputs, a negedge monitor pops and compares.
module tb_issue_replay_ctrl;
  import sys_defs::*;

  localparam int WD_MAX = 63;

  logic                      clock = 1'b0;
  logic                      reset;
  ID_EX_PACKET [WAYS-1:0]    id_packet;
  logic [WAYS-1:0]           id_valid;
  logic                      flush;
  logic [ROLLBACK_WIDTH-1:0] rollback;
  ID_EX_PACKET [WAYS-1:0]    grp_packet;
  logic [WAYS-1:0]           grp_valid;
  ID_EX_PACKET [WAYS-1:0]    issue_packet;
  logic [WAYS-1:0]           issue_valid;
  logic                      id_stall;
  logic                      replay_active;
  logic                      watchdog_err;
`ifdef ISSUE_REPLAY_STATS_EN
  logic [31:0]               stat_rollback_cycles;
  logic [31:0]               stat_replayed_insts;
`endif

  issue_replay_ctrl #(.WATCHDOG_MAX(WD_MAX)) dut (
    .clock         (clock),
    .reset         (reset),
    .id_packet     (id_packet),
    .id_valid      (id_valid),
    .flush         (flush),
    .rollback      (rollback),
    .grp_packet    (grp_packet),
    .grp_valid     (grp_valid),
    .issue_packet  (issue_packet),
    .issue_valid   (issue_valid),
    .id_stall      (id_stall),
    .replay_active (replay_active),
    .watchdog_err  (watchdog_err)
`ifdef ISSUE_REPLAY_STATS_EN
    ,
    .stat_rollback_cycles (stat_rollback_cycles),
    .stat_replayed_insts  (stat_replayed_insts)
`endif
  );

  always #5 clock = ~clock;

  typedef struct {
    logic [WAYS-1:0]        grp_valid;
    logic [WAYS-1:0]        issue_valid;
    ID_EX_PACKET [WAYS-1:0] pkt;
    logic                   stall;
    logic                   active;
    logic                   err;
    logic [31:0]            rc;
    logic [31:0]            ri;
  } exp_t;

  exp_t        exp_q[$];
  ID_EX_PACKET rq[$];          // model replay buffer, oldest first
  int          run_len;        // consecutive replay cycles seen by the model
  bit          err_sticky;
  logic [31:0] m_rc, m_ri;
  int          vectors = 0;
  int          miscompares = 0;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] req);
    vectors++;
    if (act !== req) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, req, $time);
    end
  endtask

  function automatic logic [WAYS-1:0] low_mask(input int n);
    low_mask = '0;
    for (int i = 0; i < n && i < WAYS; i++) low_mask[i] = 1'b1;
  endfunction

  task automatic model_reset();
    rq.delete();
    run_len    = 0;
    err_sticky = 0;
    m_rc       = '0;
    m_ri       = '0;
  endtask

  // Apply one cycle of stimulus (called at posedge+1), predict, push, advance.
  task automatic step(input int n_valid, input int rb, input bit fl);
    exp_t        e;
    ID_EX_PACKET grp[$];
    ID_EX_PACKET held[$];
    bit          was_replay;
    int          keep_n;
    was_replay = (rq.size() != 0);
    if (!was_replay) begin
      // decode only advances its group when it was not stalled
      for (int i = 0; i < WAYS; i++) begin
        id_packet[i].pc       = $urandom;
        id_packet[i].inst     = $urandom;
        id_packet[i].dest_reg = 5'($urandom);
      end
      id_valid = low_mask(n_valid);
    end
    flush    = fl;
    rollback = ROLLBACK_WIDTH'(rb);
    if (was_replay) grp = rq;
    else for (int i = 0; i < n_valid; i++) grp.push_back(id_packet[i]);
    keep_n = WAYS - ((rb > WAYS) ? WAYS : rb);
    e.pkt = '0;
    for (int i = 0; i < grp.size(); i++) e.pkt[i] = grp[i];
    e.grp_valid   = low_mask(grp.size());
    e.issue_valid = fl ? '0 : low_mask((keep_n < grp.size()) ? keep_n : grp.size());
    e.stall       = was_replay && !fl;
    e.active      = was_replay;
    e.err         = err_sticky;
    e.rc          = m_rc;
    e.ri          = m_ri;
    exp_q.push_back(e);
    if (!fl) for (int i = keep_n; i < grp.size(); i++) held.push_back(grp[i]);
    if (held.size() != 0) begin
      m_rc = m_rc + 1;
      m_ri = m_ri + 32'(held.size());
    end
    rq = held;
    run_len = was_replay ? run_len + 1 : 0;
    if (run_len >= WD_MAX) err_sticky = 1;
    @(posedge clock);
    #1;
  endtask

  // Monitor: every cycle the DUT presents a group; compare it with the oldest prediction.
  always @(negedge clock) begin
    if (exp_q.size() != 0) begin
      exp_t e;
      e = exp_q.pop_front();
      check("grp_valid", 128'(grp_valid), 128'(e.grp_valid));
      check("issue_valid", 128'(issue_valid), 128'(e.issue_valid));
      for (int i = 0; i < WAYS; i++) begin
        if (e.grp_valid[i]) begin
          check($sformatf("grp_packet[%0d]", i), 128'(grp_packet[i]), 128'(e.pkt[i]));
          check($sformatf("issue_packet[%0d]", i), 128'(issue_packet[i]), 128'(e.pkt[i]));
        end
      end
      check("id_stall", 128'(id_stall), 128'(e.stall));
      check("replay_active", 128'(replay_active), 128'(e.active));
      check("watchdog_err", 128'(watchdog_err), 128'(e.err));
`ifdef ISSUE_REPLAY_STATS_EN
      check("stat_rollback_cycles", 128'(stat_rollback_cycles), 128'(e.rc));
      check("stat_replayed_insts", 128'(stat_replayed_insts), 128'(e.ri));
`endif
    end
  end

  task automatic check_reset_outputs(input string tag);
    check({tag, " replay_active"}, 128'(replay_active), 128'(0));
    check({tag, " grp_valid"}, 128'(grp_valid), 128'(0));
    check({tag, " issue_valid"}, 128'(issue_valid), 128'(0));
    check({tag, " id_stall"}, 128'(id_stall), 128'(0));
    check({tag, " watchdog_err"}, 128'(watchdog_err), 128'(0));
`ifdef ISSUE_REPLAY_STATS_EN
    check({tag, " stat_rollback_cycles"}, 128'(stat_rollback_cycles), 128'(0));
    check({tag, " stat_replayed_insts"}, 128'(stat_replayed_insts), 128'(0));
`endif
  endtask

  initial begin
    reset     = 1'b1;
    id_packet = '0;
    id_valid  = '1;
    flush     = 1'b0;
    rollback  = '0;
    model_reset();
    #2;
    check_reset_outputs("reset");
    @(posedge clock);
    #1;
    reset = 1'b0;

    // Full group, no rollback.
    step(4, 0, 0);
    // Rollback 2: ways 2,3 replayed next cycle, then back to PASS.
    step(4, 2, 0);
    step(4, 0, 0);
    step(4, 0, 0);
    // Rollback 3 on a two-way group: only way 1 held.
    step(2, 3, 0);
    step(2, 0, 0);
    step(4, 0, 0);
    // Flush during a two-entry replay.
    step(4, 2, 0);
    step(4, 1, 1);
    step(4, 0, 0);
    // Rollback of invalid ways only holds nothing.
    step(1, 3, 0);
    // Watchdog: hold the full group long enough to trip it, then leave REPLAY.
    for (int i = 0; i < WD_MAX + 4; i++) step(4, 4, 0);
    for (int i = 0; i < 3; i++) step(4, 0, 0);
    // Asynchronous reset in the middle of a replay.
    step(4, 2, 0);
    reset = 1'b1;
    #1;
    check_reset_outputs("async reset");
    model_reset();
    @(posedge clock);
    #1;
    reset = 1'b0;
    // Randomized traffic.
    for (int n = 0; n < 600; n++) begin
      int r;
      r = $urandom_range(0, 9);
      step($urandom_range(0, WAYS), (r < 5) ? 0 : $urandom_range(1, 7), ($urandom_range(0, 15) == 0));
    end
    // Let the monitor drain, bounded.
    for (int i = 0; i < 4 && exp_q.size() != 0; i++) @(negedge clock);
    #1;
    if (exp_q.size() != 0) begin
      miscompares++;
      $display("FAIL drain: %0d predictions left unchecked, expected 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
